// File: rtl/conv_1_weight_pingpong_loader.sv
// conv_1 weight loader: steers one 64-bit weight stream into two ping-pong bank FIFOs,
// one pass of ifm_width*256 words per bank, alternating banks for num_passes passes.
module conv_1_weight_pingpong_loader #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [8:0]  ifm_width,
    input  logic [9:0]  num_passes,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [63:0] s_data,
    output logic        bram0_full,
    input  logic        bram0_valid,
    output logic [63:0] bram0_data,
    output logic        bram1_full,
    input  logic        bram1_valid,
    output logic [63:0] bram1_data,
    output logic        busy,
    output logic        done,
    output logic        cfg_err
);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_t;

    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    state_t      state_q;
    logic [16:0] wpp_q;
    logic [9:0]  npass_q;
    logic [16:0] word_cnt_q;
    logic [9:0]  pass_cnt_q;
    logic        wr_bank_q;
    logic        busy_q;
    logic        done_q;
    logic        cfg_err_q;
    logic        cfg_ok;

    logic [63:0]   mem_q   [2][DEPTH];
    logic [AW-1:0] wptr_q  [2];
    logic [AW-1:0] rptr_q  [2];
    logic [AW:0]   cnt_q   [2];
    logic [AW:0]   cnt_d   [2];
    logic [63:0]   rdata_q [2];
    logic [1:0]    avail_q;
    logic [1:0]    bank_full;
    logic [1:0]    push_b;
    logic [1:0]    pop_b;
    logic          push;

    assign cfg_ok = ((ifm_width == 9'd104) || (ifm_width == 9'd52) ||
                     (ifm_width == 9'd26)  || (ifm_width == 9'd13)) &&
                    (num_passes != '0);

    assign bank_full[0] = (cnt_q[0] == CNT_FULL);
    assign bank_full[1] = (cnt_q[1] == CNT_FULL);
    assign s_ready      = (state_q == S_FILL) && !bank_full[wr_bank_q];
    assign push         = s_valid & s_ready;
    assign push_b       = {push & wr_bank_q, push & ~wr_bank_q};
    // Pop is qualified by the registered availability flag, so popping an empty bank is a no-op.
    assign pop_b        = {bram1_valid & avail_q[1], bram0_valid & avail_q[0]};

    always_comb begin
        for (int unsigned b = 0; b < 2; b++) begin
            cnt_d[b] = cnt_q[b];
            if (push_b[b] && !pop_b[b]) begin
                cnt_d[b] = cnt_q[b] + CNT_ONE;
            end else if (!push_b[b] && pop_b[b]) begin
                cnt_d[b] = cnt_q[b] - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned b = 0; b < 2; b++) begin
            if (push_b[b]) begin
                mem_q[b][wptr_q[b]] <= s_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned b = 0; b < 2; b++) begin
                wptr_q[b]  <= '0;
                rptr_q[b]  <= '0;
                cnt_q[b]   <= '0;
                rdata_q[b] <= '0;
            end
            avail_q <= '0;
        end else begin
            for (int unsigned b = 0; b < 2; b++) begin
                if (push_b[b]) begin
                    wptr_q[b] <= wptr_q[b] + PTR_ONE;
                end
                if (pop_b[b]) begin
                    rdata_q[b] <= mem_q[b][rptr_q[b]];
                    rptr_q[b]  <= rptr_q[b] + PTR_ONE;
                end
                cnt_q[b]   <= cnt_d[b];
                avail_q[b] <= (cnt_d[b] != '0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            wpp_q      <= '0;
            npass_q    <= '0;
            word_cnt_q <= '0;
            pass_cnt_q <= '0;
            wr_bank_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (cfg_ok) begin
                            wpp_q      <= {ifm_width, 8'h00};
                            npass_q    <= num_passes;
                            word_cnt_q <= '0;
                            pass_cnt_q <= '0;
                            wr_bank_q  <= 1'b0;
                            busy_q     <= 1'b1;
                            state_q    <= S_FILL;
                        end else begin
                            cfg_err_q <= 1'b1;
                        end
                    end
                end
                S_FILL: begin
                    if (push) begin
                        if (word_cnt_q == wpp_q - 17'd1) begin
                            word_cnt_q <= '0;
                            pass_cnt_q <= pass_cnt_q + 10'd1;
                            wr_bank_q  <= ~wr_bank_q;
                            if (pass_cnt_q == npass_q - 10'd1) begin
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                state_q <= S_DONE;
                            end
                        end else begin
                            word_cnt_q <= word_cnt_q + 17'd1;
                        end
                    end
                end
                S_DONE: state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bram0_full = avail_q[0];
    assign bram1_full = avail_q[1];
    assign bram0_data = rdata_q[0];
    assign bram1_data = rdata_q[1];
    assign busy       = busy_q;
    assign done       = done_q;
    assign cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_conv_1_weight_pingpong_loader.sv
// Scoreboard bench for conv_1_weight_pingpong_loader: stimulus queues expected bank words,
// a negedge monitor pops and compares one cycle after each consumer pop.
module tb_conv_1_weight_pingpong_loader;

    localparam int BIG = 1 << 30;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [8:0]  ifm_width;
    logic [9:0]  num_passes;
    logic        s_valid;
    logic        s_ready;
    logic [63:0] s_data;
    logic        bram0_full;
    logic        bram0_valid;
    logic [63:0] bram0_data;
    logic        bram1_full;
    logic        bram1_valid;
    logic [63:0] bram1_data;
    logic        busy;
    logic        done;
    logic        cfg_err;

    always #5 clk = ~clk;

    conv_1_weight_pingpong_loader #(.DEPTH(16), .AW(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ifm_width(ifm_width),
        .num_passes(num_passes), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .bram0_full(bram0_full), .bram0_valid(bram0_valid), .bram0_data(bram0_data),
        .bram1_full(bram1_full), .bram1_valid(bram1_valid), .bram1_data(bram1_data),
        .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    int checks = 0;
    int failures = 0;
    logic [63:0] expq0[$];
    logic [63:0] expq1[$];
    logic [63:0] exp0, exp1;
    bit  pend0 = 0, pend1 = 0;
    int  pop_cnt0 = 0, pop_cnt1 = 0;
    int  pop_lim0 = 0, pop_lim1 = 0;
    int  acc = 0;
    int  done_cnt = 0;
    int  base;
    time t0;

    function automatic logic [63:0] wgen(input int lay, input int k);
        return {16'(lay), 16'(k), ~16'(k), 16'(k) ^ 16'h5A5A};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic start_layer(input int w, input int np);
        ifm_width  = 9'(w);
        num_passes = 10'(np);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Offers words 0..n-1 of a layer; the bank of word k is (k / wpp) % 2.
    task automatic send(input int n, input int lay, input int wpp, input int budget);
        int k = 0;
        int waited = 0;
        while (k < n) begin
            s_valid = 1'b1;
            s_data  = wgen(lay, k);
            @(negedge clk);
            if (s_ready) begin
                if (((k / wpp) % 2) == 0) expq0.push_back(wgen(lay, k));
                else                      expq1.push_back(wgen(lay, k));
                k++;
                acc = k;
                waited = 0;
            end else begin
                waited++;
                if (waited > budget) begin
                    checks++;
                    failures++;
                    $display("FAIL send_timeout: accepted %0d words, required %0d", k, n);
                    break;
                end
            end
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
    endtask

    task automatic do_reset(input int cyc);
        rst_n = 1'b0;
        repeat (cyc) @(posedge clk);
        #1;
        expq0.delete();
        expq1.delete();
        rst_n = 1'b1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        bram0_valid = 1'b0;
        bram1_valid = 1'b0;
        forever begin
            @(posedge clk); #1;
            bram0_valid = (pop_cnt0 < pop_lim0);
            bram1_valid = (pop_cnt1 < pop_lim1);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend0 = 0;
                pend1 = 0;
            end else begin
                if (pend0) check("bram0_data", bram0_data, exp0);
                if (pend1) check("bram1_data", bram1_data, exp1);
                pend0 = 0;
                pend1 = 0;
                if (done) done_cnt++;
                if (bram0_valid && bram0_full) begin
                    pop_cnt0++;
                    if (expq0.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL bank0_pop: got bram0_full=1 expected 0 (no word owed)");
                    end else begin
                        exp0 = expq0.pop_front();
                        pend0 = 1;
                    end
                end
                if (bram1_valid && bram1_full) begin
                    pop_cnt1++;
                    if (expq1.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL bank1_pop: got bram1_full=1 expected 0 (no word owed)");
                    end else begin
                        exp1 = expq1.pop_front();
                        pend1 = 1;
                    end
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; ifm_width = '0; num_passes = '0;
        s_valid = 1'b1; s_data = '0;

        // T1 reset with s_valid asserted
        wait_cycles(3);
        check("rst_s_ready", s_ready, 0);
        check("rst_bram0_full", bram0_full, 0);
        check("rst_bram1_full", bram1_full, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_cfg_err", cfg_err, 0);
        check("rst_bram0_data", bram0_data, 0);
        s_valid = 1'b0;
        rst_n = 1'b1;
        wait_cycles(1);

        // T2 width 13, two passes, consumer always popping
        pop_lim0 = BIG; pop_lim1 = BIG;
        t0 = $time;
        start_layer(13, 2);
        check("t2_busy", busy, 1);
        send(6656, 1, 3328, 50);
        check("t2_cycles", ($time - t0) / 10, 6657);
        check("t2_done_pulse", done, 1);
        check("t2_busy_drop", busy, 0);
        wait_cycles(1);
        check("t2_done_clear", done, 0);
        wait_cycles(6);
        check("t2_q0_drained", expq0.size(), 0);
        check("t2_q1_drained", expq1.size(), 0);
        check("t2_pops0", pop_cnt0, 3328);
        check("t2_pops1", pop_cnt1, 3328);
        check("t2_done_count", done_cnt, 1);
        check("t2_full0_clear", bram0_full, 0);

        // T4 rejected configurations
        s_valid = 1'b1;
        start_layer(100, 2);
        check("t4_cfg_err_w", cfg_err, 1);
        check("t4_busy_w", busy, 0);
        check("t4_s_ready_w", s_ready, 0);
        wait_cycles(1);
        check("t4_cfg_err_clear", cfg_err, 0);
        start_layer(52, 0);
        check("t4_cfg_err_np", cfg_err, 1);
        check("t4_s_ready_np", s_ready, 0);
        s_valid = 1'b0;
        wait_cycles(1);

        // T3 consumer stalled, single pops release single words
        pop_lim0 = pop_cnt0; pop_lim1 = pop_cnt1;
        wait_cycles(1);
        acc = 0;
        start_layer(13, 1);
        fork
            send(17, 2, 3328, 60);
            begin
                wait_cycles(25);
                check("t3_acc16", acc, 16);
                check("t3_s_ready_full", s_ready, 0);
                check("t3_bram0_full", bram0_full, 1);
                check("t3_bram1_full", bram1_full, 0);
                pop_lim0 = pop_cnt0 + 1;
                wait_cycles(5);
                check("t3_acc17", acc, 17);
                pop_lim0 = pop_lim0 + 3;
                wait_cycles(6);
            end
        join
        check("t3_bram0_data_k4", bram0_data, wgen(2, 3));
        do_reset(1);

        // T5 pass boundary into a full bank1 while bank0 drains
        pop_lim0 = BIG;
        pop_lim1 = pop_cnt1 + 3312;
        base = done_cnt;
        acc = 0;
        start_layer(13, 2);
        send(6656, 3, 3328, 100);
        wait_cycles(3);
        check("t5_bank1_left_full", bram1_full, 1);
        check("t5_q1_residual", expq1.size(), 16);
        acc = 0;
        start_layer(13, 2);
        fork
            send(6656, 4, 3328, 100);
            begin
                for (int i = 0; i < 5000 && acc < 3328; i++) wait_cycles(1);
                wait_cycles(5);
                check("t5_acc_boundary", acc, 3328);
                check("t5_s_ready_stall", s_ready, 0);
                check("t5_bank1_full", bram1_full, 1);
                pop_lim1 = BIG;
            end
        join
        wait_cycles(40);
        check("t5_q0_drained", expq0.size(), 0);
        check("t5_q1_drained", expq1.size(), 0);
        check("t5_done_count", done_cnt, base + 2);

        // T6 reset mid-pass of width 104
        pop_lim0 = pop_cnt0; pop_lim1 = pop_cnt1;
        wait_cycles(1);
        start_layer(104, 2);
        send(16, 5, 26624, 20);
        check("t6_bank0_full", bram0_full, 1);
        check("t6_s_ready_full", s_ready, 0);
        do_reset(1);
        check("t6_full0_after_rst", bram0_full, 0);
        check("t6_full1_after_rst", bram1_full, 0);
        check("t6_busy_after_rst", busy, 0);
        check("t6_data0_after_rst", bram0_data, 0);
        pop_lim0 = BIG; pop_lim1 = BIG;
        base = done_cnt;
        start_layer(13, 1);
        send(3328, 6, 3328, 50);
        wait_cycles(6);
        check("t6_q0_drained", expq0.size(), 0);
        check("t6_last_word", bram0_data, wgen(6, 3327));
        check("t6_done_count", done_cnt, base + 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
